// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI master port between the LSU (id 0) and the
// instruction fetch port (id 1). The address phase is arbitrated and held
// stable until granted; an in-order owner-ID FIFO routes each response back to
// its requester.
// Optional macro OBI_ARB_ROUND_ROBIN_EN: on contention, the port that did not
// win the most recent accepted transaction is preferred. Without it, data
// always beats fetch and no rr pointer exists.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    d_req_i,
  output logic                    d_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_err_o,
  input  logic                    i_req_i,
  output logic                    i_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic                    i_err_o,
  output logic                    m_req_o,
  input  logic                    m_gnt_i,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic                    m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_err_i,
  output logic                    idle_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  // ST_REQ marks "previous address phase just handshook"; it arbitrates
  // exactly like ST_IDLE. Only ST_WAIT locks the selection.
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_sel_q;
  logic                       w_sel, w_pick, w_req, w_push, w_pop, w_head;
  logic                       w_full, w_empty;
  logic [MAX_OUTSTANDING-1:0] r_ids;
  logic [PW-1:0]              r_wptr, r_rptr;
  logic [CW-1:0]              r_cnt;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);

`ifdef OBI_ARB_ROUND_ROBIN_EN
  // r_rr holds the port preferred on the next contention.
  logic r_rr;

  // Preference flips to the loser of every accepted transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_rr <= 1'b0;
    else if (w_push) r_rr <= ~w_sel;
  end

  assign w_pick = (d_req_i & i_req_i) ? r_rr : ~d_req_i;
`else
  assign w_pick = ~d_req_i;
`endif

  // Address-phase state register and locked selection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_sel_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req) r_sel_q <= w_sel;
    end
  end

  // Next state and request/select. A full FIFO only blocks new (unlocked)
  // requests; a locked request was issued while not full and stays up.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = w_pick;
    w_req       = 1'b0;
    if (r_state == ST_WAIT) begin
      w_sel = r_sel_q;
      w_req = 1'b1;
    end else begin
      w_req = (d_req_i | i_req_i) & ~w_full;
    end
    if (w_req & m_gnt_i) w_state_nxt = ST_REQ;
    else if (w_req)      w_state_nxt = ST_WAIT;
    else                 w_state_nxt = ST_IDLE;
  end

  assign w_push = w_req & m_gnt_i;
  assign w_pop  = m_rvalid_i & ~w_empty;
  assign w_head = r_ids[r_rptr];

  // In-order owner-ID FIFO; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ids  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= w_sel;
        r_wptr        <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Master address phase; zero when not requesting. Fetch is a full-word read.
  assign m_req_o   = w_req;
  assign m_addr_o  = ~w_req ? '0 : (w_sel ? i_addr_i : d_addr_i);
  assign m_we_o    = w_req & ~w_sel & d_we_i;
  assign m_be_o    = ~w_req ? '0 : (w_sel ? {BW{1'b1}} : d_be_i);
  assign m_wdata_o = (w_req & ~w_sel) ? d_wdata_i : '0;
  assign d_gnt_o   = m_gnt_i & w_req & ~w_sel;
  assign i_gnt_o   = m_gnt_i & w_req &  w_sel;

  // Response routing by FIFO head; spurious responses produce nothing.
  assign d_rvalid_o = w_pop & ~w_head;
  assign i_rvalid_o = w_pop &  w_head;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
  assign d_err_o    = d_rvalid_o & m_err_i;
  assign i_err_o    = i_rvalid_o & m_err_i;
  assign idle_o     = w_empty & ~w_req;

`ifndef SYNTHESIS
  // Protocol monitors: stray responses and requests withdrawn before grant.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(m_rvalid_i && w_empty))
        else $warning("obi_mem_arbiter: response with no outstanding transaction dropped");
      assert (!(r_state == ST_WAIT && !(r_sel_q ? i_req_i : d_req_i)))
        else $error("obi_mem_arbiter: request withdrawn before grant");
    end
  end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed steps then random traffic, all outputs
// compared every cycle against a transaction-level model (owner queue,
// pending-winner flag, arbitration rule).
module tb_obi_mem_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, MAXO = 2;
`ifdef OBI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i = 1'b0, rst_i;
  logic          d_req_i, d_gnt_o, d_we_i, d_rvalid_o, d_err_o;
  logic [AW-1:0] d_addr_i, i_addr_i, m_addr_o;
  logic [BW-1:0] d_be_i, m_be_o;
  logic [DW-1:0] d_wdata_i, d_rdata_o, i_rdata_o, m_wdata_o, m_rdata_i;
  logic          i_req_i, i_gnt_o, i_rvalid_o, i_err_o;
  logic          m_req_o, m_gnt_i, m_we_o, m_rvalid_i, m_err_i, idle_o;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
    .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .idle_o(idle_o)
  );

  int n_chk = 0, n_fail = 0;
  // Model: owners of accepted transactions, in order; a pending winner that
  // must be kept until granted; port preferred on contention (rr build).
  bit q[$];
  bit mdl_lock = 1'b0, mdl_lock_id = 1'b0, mdl_pref = 1'b0;
  bit e_req, e_sel, d_hold = 1'b0, i_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit rv, hd;
    if (mdl_lock) begin
      e_req = 1'b1; e_sel = mdl_lock_id;
    end else if (q.size() >= MAXO || !(d_req_i || i_req_i)) begin
      e_req = 1'b0; e_sel = 1'b0;
    end else begin
      e_req = 1'b1;
      if (d_req_i && i_req_i) e_sel = RR ? mdl_pref : 1'b0;
      else                    e_sel = !d_req_i;
    end
    rv = m_rvalid_i && (q.size() > 0);
    hd = rv ? q[0] : 1'b0;
    chk("m_req", 64'(m_req_o), 64'(e_req));
    chk("d_gnt", 64'(d_gnt_o), 64'(e_req & m_gnt_i & !e_sel));
    chk("i_gnt", 64'(i_gnt_o), 64'(e_req & m_gnt_i & e_sel));
    chk("m_addr", 64'(m_addr_o), !e_req ? 64'd0 : (e_sel ? 64'(i_addr_i) : 64'(d_addr_i)));
    chk("m_we", 64'(m_we_o), 64'(e_req & !e_sel & d_we_i));
    chk("m_be", 64'(m_be_o), !e_req ? 64'd0 : (e_sel ? 64'hF : 64'(d_be_i)));
    chk("m_wdata", 64'(m_wdata_o), (e_req && !e_sel) ? 64'(d_wdata_i) : 64'd0);
    chk("d_rvalid", 64'(d_rvalid_o), 64'(rv & !hd));
    chk("d_rdata", 64'(d_rdata_o), (rv && !hd) ? 64'(m_rdata_i) : 64'd0);
    chk("d_err", 64'(d_err_o), 64'(rv & !hd & m_err_i));
    chk("i_rvalid", 64'(i_rvalid_o), 64'(rv & hd));
    chk("i_rdata", 64'(i_rdata_o), (rv && hd) ? 64'(m_rdata_i) : 64'd0);
    chk("i_err", 64'(i_err_o), 64'(rv & hd & m_err_i));
    chk("idle", 64'(idle_o), 64'((q.size() == 0) && !e_req));
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances the
  // model on the clock edge.
  task automatic step();
    #3;
    check_all();
    d_hold = d_req_i && !(e_req && m_gnt_i && !e_sel);
    i_hold = i_req_i && !(e_req && m_gnt_i && e_sel);
    @(posedge clk_i);
    if (rst_i) begin
      q.delete(); mdl_lock = 1'b0; mdl_pref = 1'b0;
    end else begin
      if (m_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (e_req && m_gnt_i) begin
        q.push_back(e_sel); mdl_lock = 1'b0; mdl_pref = !e_sel;
      end else if (e_req) begin
        mdl_lock = 1'b1; mdl_lock_id = e_sel;
      end
    end
    #1;
  endtask

  task automatic new_d();
    if (!d_hold) begin
      d_addr_i = $urandom; d_we_i = 1'($urandom); d_be_i = 4'($urandom); d_wdata_i = $urandom;
    end
  endtask

  // Finish held requests and outstanding responses with an always-ready bus.
  task automatic drain();
    for (int k = 0; k < 20 && (d_hold || i_hold || q.size() > 0); k++) begin
      d_req_i = d_hold; i_req_i = i_hold; m_gnt_i = 1'b1;
      m_rvalid_i = (q.size() > 0); m_rdata_i = $urandom; m_err_i = 1'b0;
      step();
    end
    d_req_i = 1'b0; i_req_i = 1'b0; m_rvalid_i = 1'b0;
    #2; chk("drain_idle", 64'(idle_o), 64'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; d_req_i = 0; d_addr_i = 0; d_we_i = 0; d_be_i = 0; d_wdata_i = 0;
    i_req_i = 0; i_addr_i = 0; m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_err_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    step();                       // reset values
    rst_i = 1'b0;

    // Contention with an always-ready bus, response one cycle after grant.
    for (int k = 0; k < 6; k++) begin
      new_d(); d_req_i = 1'b1;
      if (!i_hold) i_addr_i = 32'h1000 + 32'(4 * k);
      i_req_i = 1'b1; m_gnt_i = 1'b1;
      m_rvalid_i = (q.size() > 0); m_rdata_i = $urandom; m_err_i = 1'b0;
      step();
    end
    drain();

    // Held address phase: 3 wait cycles, fetch arrives while locked on data.
    d_req_i = 1'b1; d_addr_i = 32'h100; d_we_i = 1'b1; d_be_i = 4'h3; d_wdata_i = 32'hCAFE;
    m_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin i_req_i = 1'b1; i_addr_i = 32'h40; end
      if (k == 3) m_gnt_i = 1'b1;
      #2; chk("hold_addr", 64'(m_addr_o), 64'h100);
      step();
    end
    d_req_i = 1'b0;
    #2; chk("fetch_after_hold", 64'(i_gnt_o), 64'd1);
    step();
    drain();

    // Backpressure: third fetch blocked by a full owner FIFO.
    m_gnt_i = 1'b1; i_req_i = 1'b1;
    i_addr_i = 32'h0; step();
    i_addr_i = 32'h4; step();
    i_addr_i = 32'h8;
    #2; chk("full_block", 64'(m_req_o), 64'd0);
    step();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h11; step();
    m_rvalid_i = 1'b0;
    #2; chk("full_release", 64'(m_req_o), 64'd1);
    step();
    drain();

    // Interleaved owners with push+pop in the same cycle, error on second.
    d_req_i = 1'b1; d_addr_i = 32'h200; d_we_i = 1'b0; m_gnt_i = 1'b1; step();
    d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h10;
    m_rvalid_i = 1'b1; m_rdata_i = 32'hAAAA; m_err_i = 1'b0;
    #2; chk("il_d_rdata", 64'(d_rdata_o), 64'hAAAA);
    step();
    i_req_i = 1'b0; m_rdata_i = 32'h5555; m_err_i = 1'b1;
    #2; chk("il_i_rdata", 64'(i_rdata_o), 64'h5555);
    chk("il_i_err", 64'(i_err_o), 64'd1);
    chk("il_d_err", 64'(d_err_o), 64'd0);
    step();
    m_rvalid_i = 1'b0; m_err_i = 1'b0;
    drain();

    // Reset with two outstanding, then a stray response.
    d_req_i = 1'b1; d_addr_i = 32'h300; step();
    d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h20; step();
    i_req_i = 1'b0; m_gnt_i = 1'b0; rst_i = 1'b1; step();
    rst_i = 1'b0;
    #2; chk("rst_idle", 64'(idle_o), 64'd1);
    step();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hBEEF; step();
    m_rvalid_i = 1'b0;

    // Random OBI-legal traffic.
    for (int n = 0; n < 400; n++) begin
      if (!d_hold) begin d_req_i = 1'($urandom); new_d(); end
      if (!i_hold) begin i_req_i = 1'($urandom); i_addr_i = $urandom; end
      m_gnt_i = 1'($urandom);
      m_rvalid_i = (q.size() > 0) && 1'($urandom);
      m_rdata_i = $urandom; m_err_i = 1'($urandom);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
